// File: rtl/button_debounce_n_if.sv
// rtl/button_debounce_n_if.sv - button/LED bundle between board pins, control logic and button_debounce_n
// Optional macro LONGPRESS_EN adds the BUT_LONG pulse vector.
interface button_debounce_n_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] BUT;
  logic [N_CH-1:0] MODE;
  logic [N_CH-1:0] BUT_LEVEL;
  logic [N_CH-1:0] BUT_PRESS;
  logic [N_CH-1:0] BUT_RELEASE;
  logic [N_CH-1:0] LED;
`ifdef LONGPRESS_EN
  logic [N_CH-1:0] BUT_LONG;
`endif

  // Board/control side: supplies raw pins and LED mode, consumes debounced state
  modport master (
    output BUT,
    output MODE,
    input  BUT_LEVEL,
    input  BUT_PRESS,
    input  BUT_RELEASE,
    input  LED
`ifdef LONGPRESS_EN
    , input BUT_LONG
`endif
  );

  // Debouncer side
  modport slave (
    input  BUT,
    input  MODE,
    output BUT_LEVEL,
    output BUT_PRESS,
    output BUT_RELEASE,
    output LED
`ifdef LONGPRESS_EN
    , output BUT_LONG
`endif
  );
endinterface

// File: rtl/button_debounce_n.sv
// rtl/button_debounce_n.sv - N-channel button synchroniser, debounce, edge pulses and LED driver
// Optional macro LONGPRESS_EN adds a saturating hold counter and BUT_LONG pulse per channel.
module button_debounce_n #(
  parameter int N_CH           = 2,
  parameter int DEB_CYCLES     = 1000000,
  parameter int CNT_W          = 20,
  parameter int BUT_ACTIVE_LOW = 1,
  parameter int LONG_CYCLES    = 100000000
) (
  input logic                CLK,
  input logic                RST_N,
  button_debounce_n_if.slave bus
);

  // Raw level of a released button; the synchroniser resets to it so reset exit looks idle.
  localparam logic [N_CH-1:0]  INACT    = {N_CH{BUT_ACTIVE_LOW != 0}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || ((64'd1 << CNT_W) < 64'(DEB_CYCLES)) || LONG_CYCLES < 2) begin : g_param_check
    $error("button_debounce_n: illegal DEB_CYCLES/CNT_W/LONG_CYCLES");
  end

  logic [N_CH-1:0]  sync1_q;
  logic [N_CH-1:0]  sync2_q;
  logic [N_CH-1:0]  p;
  logic [N_CH-1:0]  accept;
  logic [N_CH-1:0]  level_nx;
  logic [N_CH-1:0]  level_q;
  logic [N_CH-1:0]  press_q;
  logic [N_CH-1:0]  release_q;
  logic [N_CH-1:0]  led_q;
  logic [CNT_W-1:0] cnt_q [N_CH];

  // Two-flop metastability synchroniser on the raw pins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= INACT;
      sync2_q <= INACT;
    end else begin
      sync1_q <= bus.BUT;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity so p = 1 always means pressed
  assign p = sync2_q ^ INACT;

  // A new level is accepted once p has differed from the current level for DEB_CYCLES cycles
  always_comb begin
    accept   = '0;
    level_nx = level_q;
    for (int i = 0; i < N_CH; i++) begin
      accept[i] = (p[i] != level_q[i]) && (cnt_q[i] == DEB_LAST);
      if (accept[i]) begin
        level_nx[i] = p[i];
      end
    end
  end

  // Stability counters: any return to the current level discards the partial count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (p[i] == level_q[i] || accept[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level and its press/release pulses share one register stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      level_q   <= level_nx;
      press_q   <= accept & p;
      release_q <= accept & ~p;
    end
  end

  // LED follows the next level in follow mode, flips on accepted presses in toggle mode
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.MODE[i]) begin
          if (accept[i] && p[i]) begin
            led_q[i] <= ~led_q[i];
          end
        end else begin
          led_q[i] <= level_nx[i];
        end
      end
    end
  end

  assign bus.BUT_LEVEL   = level_q;
  assign bus.BUT_PRESS   = press_q;
  assign bus.BUT_RELEASE = release_q;
  assign bus.LED         = led_q;

`ifdef LONGPRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q [N_CH];
  logic [N_CH-1:0]   long_w;

  // Hold counter reads 0 in the BUT_PRESS cycle and saturates so the pulse cannot repeat
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!level_q[i]) begin
          hold_q[i] <= '0;
        end else if (hold_q[i] != {HOLD_W{1'b1}}) begin
          hold_q[i] <= hold_q[i] + HOLD_W'(1);
        end
      end
    end
  end

  // Long-press pulse decoded from registered state only
  always_comb begin
    long_w = '0;
    for (int i = 0; i < N_CH; i++) begin
      long_w[i] = level_q[i] && (hold_q[i] == LONG_LAST);
    end
  end

  assign bus.BUT_LONG = long_w;
`else
`endif

endmodule

// File: tb/tb_button_debounce_n.sv
// tb/tb_button_debounce_n.sv - randomized and scenario bench for button_debounce_n against a window model
module tb_button_debounce_n;
  localparam int N    = 2;
  localparam int DEB  = 8;
  localparam int LONG = 20;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  button_debounce_n_if #(.N_CH(N)) bif ();

  button_debounce_n #(
    .N_CH(N), .DEB_CYCLES(DEB), .CNT_W(4), .BUT_ACTIVE_LOW(1), .LONG_CYCLES(LONG)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bif.slave)
  );

  always #5 CLK = ~CLK;

  logic [N-1:0] dut_long;
`ifdef LONGPRESS_EN
  assign dut_long = bif.BUT_LONG;
`else
  assign dut_long = '0;
`endif
  wire [5*N-1:0] dut_out = {dut_long, bif.BUT_LEVEL, bif.BUT_PRESS, bif.BUT_RELEASE, bif.LED};

  // Reference: a level is accepted when the last DEB pressed-samples all disagree with it
  logic [N-1:0]   m_s1, m_s2, m_level, m_press, m_rel, m_led, m_long;
  logic [DEB-1:0] m_win [N];
  int             m_since [N];

  function automatic logic [5*N-1:0] model_out();
    return {m_long, m_level, m_press, m_rel, m_led};
  endfunction

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1;
    m_level = '0; m_press = '0; m_rel = '0; m_led = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      m_win[c] = '0;
      m_since[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] p;
    logic acc;
    p = ~m_s2;
    m_s2 = m_s1;
    m_s1 = bif.BUT;
    for (int c = 0; c < N; c++) begin
      m_win[c] = {m_win[c][DEB-2:0], p[c]};
      acc = (m_win[c] == (m_level[c] ? {DEB{1'b0}} : {DEB{1'b1}}));
      m_press[c] = acc & p[c];
      m_rel[c]   = acc & ~p[c];
      if (acc) m_level[c] = p[c];
      if (bif.MODE[c]) begin
        if (m_press[c]) m_led[c] = ~m_led[c];
      end else begin
        m_led[c] = m_level[c];
      end
      if (m_press[c]) m_since[c] = 0;
      else if (m_level[c] && m_since[c] < 1000) m_since[c]++;
`ifdef LONGPRESS_EN
      m_long[c] = m_level[c] && (m_since[c] == LONG - 1);
`else
      m_long[c] = 1'b0;
`endif
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; bif.BUT = 2'b00; bif.MODE = 2'b00;
    #1; model_reset();
    repeat (3) tick();
    n_chk++;
    if (dut_out !== '0) $display("FAIL reset_outputs got=%b exp=0", dut_out);
    else n_pass++;
    RST_N = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_chk++;
      if ({bif.BUT_LEVEL[0], bif.BUT_PRESS[0]} !== {k >= 10, k == 10})
        $display("FAIL reset_exit_latency k=%0d got=%b exp=%b", k,
                 {bif.BUT_LEVEL[0], bif.BUT_PRESS[0]}, {k >= 10, k == 10});
      else n_pass++;
      n_chk++;
      if (dut_out !== model_out()) $display("FAIL reset_model k=%0d got=%b exp=%b", k, dut_out, model_out());
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int pulses;
    bif.BUT = 2'b11;
    repeat (12) tick();
    pulses = 0;
    for (int ph = 0; ph < 10; ph++) begin
      bif.BUT[0] = ph[0];
      repeat (3) begin
        tick();
        pulses += int'(bif.BUT_PRESS[0]) + int'(bif.BUT_RELEASE[0]);
        n_chk++;
        if (dut_out !== model_out()) $display("FAIL bounce_model got=%b exp=%b", dut_out, model_out());
        else n_pass++;
      end
    end
    n_chk++;
    if (pulses !== 0) $display("FAIL bounce_pulses got=%0d exp=0", pulses);
    else n_pass++;
    bif.BUT[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_chk++;
      if (bif.BUT_PRESS[0] !== (k == 10)) $display("FAIL bounce_settle k=%0d got=%b exp=%b", k, bif.BUT_PRESS[0], k == 10);
      else n_pass++;
    end
  endtask

  task automatic test_toggle();
    int rels;
    logic exp_led;
    rels = 0;
    bif.MODE = 2'b10;
    for (int r = 0; r < 3; r++) begin
      exp_led = (r != 1);
      bif.BUT[1] = 1'b0;
      repeat (12) tick();
      n_chk++;
      if (bif.LED[1] !== exp_led) $display("FAIL toggle_press r=%0d got=%b exp=%b", r, bif.LED[1], exp_led);
      else n_pass++;
      bif.BUT[1] = 1'b1;
      repeat (12) begin
        tick();
        rels += int'(bif.BUT_RELEASE[1]);
      end
      n_chk++;
      if (bif.LED[1] !== exp_led) $display("FAIL toggle_release r=%0d got=%b exp=%b", r, bif.LED[1], exp_led);
      else n_pass++;
    end
    n_chk++;
    if (rels !== 3) $display("FAIL toggle_release_count got=%0d exp=3", rels);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bif.MODE = 2'b00; bif.BUT = 2'b11;
    repeat (12) tick();
    bif.BUT = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_chk++;
      if (bif.BUT_PRESS !== ((k == 10) ? 2'b11 : 2'b00)) $display("FAIL simul_press k=%0d got=%b", k, bif.BUT_PRESS);
      else n_pass++;
    end
    bif.BUT = 2'b11;
    repeat (5) tick();
    RST_N = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (dut_out !== '0) $display("FAIL midcount_reset got=%b exp=0", dut_out);
    else n_pass++;
    tick();
    RST_N = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_chk++;
      if (dut_out !== '0) $display("FAIL reset_exit_quiet k=%0d got=%b exp=0", k, dut_out);
      else n_pass++;
    end
  endtask

  task automatic test_mode_switch();
    bif.MODE = 2'b01; bif.BUT[0] = 1'b0;
    repeat (12) tick();
    bif.BUT[0] = 1'b1;
    repeat (12) tick();
    n_chk++;
    if ({bif.LED[0], bif.BUT_LEVEL[0]} !== 2'b10) $display("FAIL mode_setup got=%b exp=10", {bif.LED[0], bif.BUT_LEVEL[0]});
    else n_pass++;
    bif.MODE[0] = 1'b0;
    tick();
    n_chk++;
    if (bif.LED[0] !== 1'b0) $display("FAIL mode_switch_led got=%b exp=0", bif.LED[0]);
    else n_pass++;
  endtask

`ifdef LONGPRESS_EN
  task automatic test_long();
    int cnt, at, w;
    bif.MODE = 2'b00; bif.BUT = 2'b11;
    repeat (12) tick();
    for (int pass = 0; pass < 2; pass++) begin
      bif.BUT[0] = 1'b0;
      w = 0;
      while (!bif.BUT_PRESS[0] && w < 20) begin
        tick();
        w++;
      end
      n_chk++;
      if (!bif.BUT_PRESS[0]) $display("FAIL long_wait_press pass=%0d got=timeout exp=press", pass);
      else n_pass++;
      cnt = 0; at = -1;
      for (int k = 1; k <= 40; k++) begin
        if (pass == 1 && k == 5) bif.BUT[0] = 1'b1;
        tick();
        if (bif.BUT_LONG[0]) begin
          cnt++;
          at = k;
        end
      end
      n_chk++;
      if (pass == 0 && (cnt !== 1 || at !== 19)) $display("FAIL long_hold got=%0d@%0d exp=1@19", cnt, at);
      else if (pass == 1 && cnt !== 0) $display("FAIL long_short got=%0d exp=0", cnt);
      else n_pass++;
      bif.BUT[0] = 1'b1;
      repeat (12) tick();
    end
  endtask
`endif

  task automatic test_random();
    int hold [N];
    for (int c = 0; c < N; c++) hold[c] = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          bif.BUT[c] = ~bif.BUT[c];
          hold[c] = $urandom_range(1, 14);
          if ($urandom_range(0, 3) == 0) hold[c] += LONG + 10;
        end
      end
      if ($urandom_range(0, 49) == 0) bif.MODE[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        RST_N = 1'b0;
        model_reset();
      end else begin
        RST_N = 1'b1;
      end
      tick();
      n_chk++;
      if (dut_out !== model_out()) $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, dut_out, model_out());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_toggle();
    test_simultaneous();
    test_mode_switch();
`ifdef LONGPRESS_EN
    test_long();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/button_debounce_n.md
Name: button_debounce_n

Overview:
Parametrised N-channel button front end for the scope board. It replaces the bare two-flop capture with several stages per channel:
- metastability synchroniser
- counter-based debounce
- press/release edge pulses
- per-channel LED driver with follow or toggle mode

It sits between the board buttons and the control logic (trigger arm, mode select) and drives the status LEDs directly.

Parameters:
N_CH, 2, number of button/LED channels (1..16)
DEB_CYCLES, 1000000, number of consecutive stable CLK cycles needed to accept a new level (10 ms at 100 MHz); must be >= 2
CNT_W, 20, debounce counter width; 2**CNT_W must be >= DEB_CYCLES
BUT_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed
LONG_CYCLES, 100000000, long-press threshold in CLK cycles (used only with LONGPRESS_EN)

Ports:
CLK  input  1  system clock, 100 MHz, all logic on posedge
RST_N  input  1  asynchronous active-low reset
BUT  input  N_CH  raw asynchronous button pins
MODE  input  N_CH  per-channel LED mode: 0 = follow, 1 = toggle; synchronous to CLK
BUT_LEVEL  output  N_CH  debounced pressed state, 1 = pressed
BUT_PRESS  output  N_CH  one-cycle pulse on accepted press
BUT_RELEASE  output  N_CH  one-cycle pulse on accepted release
LED  output  N_CH  LED drive, 1 = lit
BUT_LONG  output  N_CH  one-cycle long-press pulse (present only with LONGPRESS_EN)

Behaviour:
- Single clock domain CLK. RST_N is asynchronous assert and synchronous deassert; the deassert is handled upstream.
- Reset values:
  - Synchroniser flops hold the inactive raw level: 1 if BUT_ACTIVE_LOW, else 0.
  - Counters are 0.
  - BUT_LEVEL, BUT_PRESS, BUT_RELEASE, LED and BUT_LONG are all 0.
- Synchroniser: two flops per channel. Polarity is normalised after the second flop, so p = 1 means pressed.
- Debounce, per channel, evaluated each cycle:
  - If p == BUT_LEVEL: counter <= 0.
  - Else if counter == DEB_CYCLES-1: BUT_LEVEL <= p and counter <= 0.
  - Else: counter <= counter+1.
- Any bounce (p returning to BUT_LEVEL) clears the counter; partial counts are never retained.
- Latency: a clean edge on BUT changes BUT_LEVEL exactly 2+DEB_CYCLES cycles later.
- Edge pulses:
  - BUT_PRESS is high for exactly one cycle, the first cycle BUT_LEVEL reads 1.
  - BUT_RELEASE is high for exactly one cycle, the first cycle BUT_LEVEL reads 0.
  - Both are registered together with BUT_LEVEL, so there is no added latency.
  - Press and release on the same channel can never coincide.
- LED, registered, updated on the same edge as BUT_LEVEL:
  - MODE=0: LED equals the next BUT_LEVEL value.
  - MODE=1: LED inverts on each accepted press and ignores releases.
  - MODE 1->0: LED takes BUT_LEVEL on the next cycle.
  - MODE 0->1: LED holds its current value until the next press.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset mid-count: counter cleared, BUT_LEVEL back to 0, and no pulse is emitted on reset entry or exit.
- Counter never exceeds DEB_CYCLES-1; there is no wrap.

Optional Feature:
Macro LONGPRESS_EN.
- Defined:
  - Each channel gains a hold counter, width $clog2(LONG_CYCLES+1), saturating.
  - The counter clears when BUT_LEVEL=0 and increments while BUT_LEVEL=1.
  - BUT_LONG pulses one cycle when the count reaches LONG_CYCLES-1 (counted from the cycle BUT_PRESS asserts).
  - At most one BUT_LONG pulse per press.
  - Release before threshold: no pulse.
  - In toggle mode a long press does not change LED any differently.
- Undefined: BUT_LONG port and hold counters are absent; all other behaviour is identical.

Test Plan (DEB_CYCLES=8, LONG_CYCLES=20, N_CH=2, BUT_ACTIVE_LOW=1):
1. Reset: hold RST_N=0 with BUT=2'b00 -> all outputs 0. Release reset -> BUT_LEVEL[0] rises after 2+8=10 cycles, with BUT_PRESS[0] high that same cycle only.
2. Bounce: BUT[0] toggles 0/1 every 3 cycles for 30 cycles, then settles at 0 -> no pulses during bouncing. BUT_PRESS[0] fires exactly 10 cycles after the final settle.
3. Toggle mode: MODE[1]=1; press/release BUT[1] cleanly three times -> LED[1] sequence 1,0,1. Three BUT_RELEASE[1] pulses. LED[1] unchanged on releases.
4. Simultaneous events: both buttons pressed on the same cycle -> BUT_PRESS=2'b11 in one cycle. Then RST_N pulsed low mid-count during release -> no BUT_RELEASE, outputs 0.
5. Mode switch: MODE[0]=1 with LED[0]=1 and button released; switch MODE[0]=0 -> LED[0]=0 on the next cycle.
6. LONGPRESS_EN: hold BUT[0] pressed 40 cycles past BUT_PRESS -> one BUT_LONG[0] pulse at cycle 19 after BUT_PRESS. Press held only 15 cycles -> no pulse.
